// File: rtl/core_pkg.sv
// Shared types and constants for the core front end.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    HOLD = 2'b11
  } fetch_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_BUS_ERR  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } fault_cause_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter bounding how long a fetch may sit in REQ/WAIT.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Fires in the cycle whose increment would reach TIMEOUT_CYC.
  assign expired = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read per fetch strobe
// and holds the result (or a fault) for decode until acknowledged.
module fetch_unit
  import core_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int               TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_start,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_err,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ack,
  output logic            fetch_fault,
  output logic [1:0]      fault_cause,
  output logic            busy
);

  fetch_state_t    state_q, state_d;
  fault_cause_t    cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic            ctr_clr;
  logic            ctr_en;
  logic            expired;
  logic            redirect_hit;
  logic [XLEN-1:0] redirect_tgt;

  assign ctr_en = (state_q == REQ) || (state_q == WAIT);

  fetch_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  // A redirect arriving in the same cycle as completion overrides the pending one.
  assign redirect_hit = redirect_valid || pend_valid_q;
  assign redirect_tgt = redirect_valid ? redirect_pc : pend_pc_q;

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    ctr_clr      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (fetch_start) begin
          if (pc_q[1:0] != 2'b00) begin
            state_d = HOLD;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = REQ;
            cause_d = CAUSE_NONE;
            ctr_clr = 1'b1;
          end
        end
      end

      REQ, WAIT: begin
        if (redirect_valid) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc;
        end
        if ((state_q == WAIT) && imem_rvalid) begin
          if (redirect_hit) begin
            state_d      = IDLE;
            pc_d         = redirect_tgt;
            pend_valid_d = 1'b0;
          end else begin
            state_d    = HOLD;
            instr_pc_d = pc_q;
            if (imem_err) begin
              cause_d = CAUSE_BUS_ERR;
            end else begin
              cause_d = CAUSE_NONE;
              instr_d = imem_rdata;
            end
          end
        end else if (expired) begin
          if (redirect_hit) begin
            state_d      = IDLE;
            pc_d         = redirect_tgt;
            pend_valid_d = 1'b0;
          end else begin
            state_d = HOLD;
            cause_d = CAUSE_TIMEOUT;
          end
        end else if ((state_q == REQ) && imem_gnt) begin
          state_d = WAIT;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          state_d = IDLE;
          pc_d    = redirect_pc;
        end else if (instr_ack) begin
          state_d = IDLE;
          if (cause_q == CAUSE_NONE) begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cause_q      <= CAUSE_NONE;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      instr_pc_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = (state_q == REQ) ? pc_q : '0;
  assign instr_valid = (state_q == HOLD) && (cause_q == CAUSE_NONE);
  assign fetch_fault = (state_q == HOLD) && (cause_q != CAUSE_NONE);
  assign fault_cause = (state_q == HOLD) ? cause_q : CAUSE_NONE;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected responses into a
// queue, an independent monitor pops and compares on each presentation.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ack = 1'b0;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic        busy;

  typedef struct {
    logic        isFault;
    logic [1:0]  cause;
    logic [31:0] instr;
    logic [31:0] pc;
  } expRsp_t;

  expRsp_t expQ[$];
  int      total = 0;
  int      bad = 0;
  logic    presentPrev = 1'b0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT_CYC(255)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_start    (fetch_start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ack      (instr_ack),
    .fetch_fault    (fetch_fault),
    .fault_cause    (fault_cause),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic waitPresent(input int limit, input string name);
    int n = 0;
    while (!(instr_valid || fetch_fault) && n < limit) begin
      tick();
      n++;
    end
    if (!(instr_valid || fetch_fault)) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: no response after %0d cycles, expected one", name, limit);
    end
  endtask

  // Full fetch with a one-cycle grant and rvalid the cycle after, then ack.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic err);
    expRsp_t e;
    e.isFault = err;
    e.cause   = err ? 2'b10 : 2'b00;
    e.instr   = data;
    e.pc      = addr;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    checkOutput("req_up", 32'(imem_req), 1);
    checkOutput("req_addr", imem_addr, addr);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checkOutput("req_drop", 32'(imem_req), 0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    imem_err    = err;
    expQ.push_back(e);
    tick();
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    waitPresent(4, "rsp_wait");
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    checkOutput("idle_after_ack", 32'(busy), 0);
  endtask

  task automatic pushFault(input logic [1:0] cause);
    expRsp_t e;
    e.isFault = 1'b1;
    e.cause   = cause;
    e.instr   = '0;
    e.pc      = '0;
    expQ.push_back(e);
  endtask

  // Monitor: on the first cycle of each presentation, pop and compare.
  initial begin
    expRsp_t e;
    logic    present;
    forever begin
      @(negedge clk);
      present = rst_n && (instr_valid || fetch_fault);
      if (present && !presentPrev) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rsp: got valid=%0b fault=%0b, expected none", instr_valid, fetch_fault);
        end else begin
          e = expQ.pop_front();
          if (e.isFault) begin
            checkOutput("mon_fault", 32'(fetch_fault), 1);
            checkOutput("mon_fault_nvalid", 32'(instr_valid), 0);
            checkOutput("mon_cause", 32'(fault_cause), 32'(e.cause));
          end else begin
            checkOutput("mon_valid", 32'(instr_valid), 1);
            checkOutput("mon_nfault", 32'(fetch_fault), 0);
            checkOutput("mon_instr", instr, e.instr);
            checkOutput("mon_pc", instr_pc, e.pc);
          end
        end
      end
      presentPrev = present;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting fetch_unit bench");
    tick();
    tick();
    checkOutput("rst_instr", instr, 32'h0000_0013);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_req", 32'(imem_req), 0);
    checkOutput("rst_valid", 32'(instr_valid), 0);
    checkOutput("rst_cause", 32'(fault_cause), 0);
    rst_n = 1'b1;
    tick();

    // Basic fetch latency and PC increment.
    applyStimulus(32'h0, 32'h0050_0093, 1'b0);
    applyStimulus(32'h4, 32'h0010_0113, 1'b0);

    // Misaligned PC faults with no bus traffic and the PC stays put.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pushFault(2'b01);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      checkOutput("mis_no_req", 32'(imem_req), 0);
      checkOutput("mis_cause", 32'(fault_cause), 1);
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
    end

    // Redirect beats a simultaneous fetch_start.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    fetch_start    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    fetch_start    = 1'b0;
    checkOutput("redir_wins", 32'(busy), 0);

    // Bus error, then retry at the same address.
    applyStimulus(32'h10, 32'h0, 1'b1);
    checkOutput("err_instr_kept", instr, 32'h0010_0113);
    applyStimulus(32'h10, 32'h00A0_0113, 1'b0);

    // Timeout with the grant withheld; a late rvalid is ignored.
    pushFault(2'b11);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    checkOutput("to_addr", imem_addr, 32'h14);
    repeat (254) tick();
    checkOutput("to_still_req", 32'(imem_req), 1);
    checkOutput("to_no_fault", 32'(fetch_fault), 0);
    tick();
    checkOutput("to_cause", 32'(fault_cause), 3);
    checkOutput("to_req_drop", 32'(imem_req), 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    checkOutput("to_hold_stable", 32'(fault_cause), 3);
    checkOutput("to_instr_kept", instr, 32'h00A0_0113);
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;

    // Redirect during WAIT: response discarded, next fetch at target.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    checkOutput("rw_addr", imem_addr, 32'h14);
    imem_gnt = 1'b1;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h0BAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    checkOutput("rw_idle", 32'(busy), 0);
    checkOutput("rw_instr_kept", instr, 32'h00A0_0113);
    tick();
    applyStimulus(32'h200, 32'h0030_0193, 1'b0);

    // Reset in WAIT, then a stray rvalid.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_instr", instr, 32'h0000_0013);
    checkOutput("mid_rst_pc", instr_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    checkOutput("stray_busy", 32'(busy), 0);
    checkOutput("stray_instr", instr, 32'h0000_0013);
    applyStimulus(32'h0, 32'h0040_0213, 1'b0);

    tick();
    checkOutput("queue_drained", 32'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
